// File: rtl/lock_pkg.sv
// Shared types and defaults for the keypad lock controller.
package lock_pkg;

    localparam int DEFAULT_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTRY   = 2'd1,
        OPEN    = 2'd2,
        LOCKOUT = 2'd3
    } lock_state_e;

    // Power-on combination is 1,2,3,... by position.
    function automatic int unsigned default_digit(input int idx);
        return int'(idx) + 1;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the OPEN hold time and the LOCKOUT period.
module lock_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/lock_controller.sv
// Keypad lock sequencer: code register file, digit compare, FSM, fail counter
// and the shared OPEN/LOCKOUT timer.
module lock_controller
    import lock_pkg::*;
#(
    parameter int DIGIT_W        = DEFAULT_DIGIT_W,
    parameter int CODE_LEN       = 3,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int OPEN_CYCLES    = 8,
    localparam int IDX_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1,
    localparam int PROG_W  = $clog2(CODE_LEN + 1),
    localparam int FAIL_W  = $clog2(MAX_TRIES + 1)
) (
    input  logic               clock_i,
    input  logic               reset_ni,
    input  logic [DIGIT_W-1:0] value_i,
    input  logic               new_i,
    input  logic               cfg_we_i,
    input  logic [IDX_W-1:0]   cfg_idx_i,
    input  logic [DIGIT_W-1:0] cfg_digit_i,
    output logic               opened_o,
    output logic               locked_out_o,
    output logic [PROG_W-1:0]  progress_o,
    output logic [FAIL_W-1:0]  fail_count_o
);

    localparam int TMAX    = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;

    lock_state_e        state_q, state_d;
    logic [PROG_W-1:0]  progress_q, progress_d;
    logic [FAIL_W-1:0]  fail_q, fail_d;
    logic               opened_q, opened_d;
    logic               locked_q, locked_d;
    logic [DIGIT_W-1:0] code_q [CODE_LEN];

    logic               timer_load;
    logic [TIMER_W-1:0] timer_val;
    logic               timer_en;
    logic               timer_zero;
    logic               cfg_write;

    lock_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk_i      (clock_i),
        .rst_ni     (reset_ni),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .en_i       (timer_en),
        .zero_o     (timer_zero)
    );

    assign timer_en  = (state_q == OPEN) || (state_q == LOCKOUT);
    // Digit strobes take priority over configuration writes.
    assign cfg_write = cfg_we_i && !new_i && (state_q == IDLE) && (int'(cfg_idx_i) < CODE_LEN);

    always_comb begin
        state_d    = state_q;
        progress_d = progress_q;
        fail_d     = fail_q;
        timer_load = 1'b0;
        timer_val  = '0;
        unique case (state_q)
            IDLE, ENTRY: begin
                if (new_i) begin
                    if (value_i == code_q[progress_q]) begin
                        if (progress_q == PROG_W'(CODE_LEN - 1)) begin
                            state_d    = OPEN;
                            progress_d = '0;
                            fail_d     = '0;
                            timer_load = 1'b1;
                            timer_val  = TIMER_W'(OPEN_CYCLES - 1);
                        end else begin
                            state_d    = ENTRY;
                            progress_d = progress_q + PROG_W'(1);
                        end
                    end else begin
                        state_d    = IDLE;
                        progress_d = '0;
                        if (int'(fail_q) + 1 >= MAX_TRIES) begin
                            state_d    = LOCKOUT;
                            fail_d     = FAIL_W'(MAX_TRIES);
                            timer_load = 1'b1;
                            timer_val  = TIMER_W'(LOCKOUT_CYCLES - 1);
                        end else begin
                            fail_d = fail_q + FAIL_W'(1);
                        end
                    end
                end
            end
            OPEN: begin
                if (new_i || timer_zero) begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (timer_zero) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        opened_d = (state_d == OPEN);
        locked_d = (state_d == LOCKOUT);
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            progress_q <= '0;
            fail_q     <= '0;
            opened_q   <= 1'b0;
            locked_q   <= 1'b0;
            for (int i = 0; i < CODE_LEN; i++) begin
                code_q[i] <= DIGIT_W'(default_digit(i));
            end
        end else begin
            state_q    <= state_d;
            progress_q <= progress_d;
            fail_q     <= fail_d;
            opened_q   <= opened_d;
            locked_q   <= locked_d;
            if (cfg_write) begin
                code_q[cfg_idx_i] <= cfg_digit_i;
            end
        end
    end

    assign opened_o     = opened_q;
    assign locked_out_o = locked_q;
    assign progress_o   = progress_q;
    assign fail_count_o = fail_q;

endmodule

// File: tb/tb_lock_controller.sv
// Directed scenarios plus randomized traffic against a cycle-count reference model.
module tb_lock_controller;

    localparam int DIGIT_W = 4;
    localparam int CODE_LEN = 3;
    localparam int MAX_TRIES = 3;
    localparam int LOCK_CYC = 16;
    localparam int OPEN_CYC = 8;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] value;
    logic       new_s;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic [3:0] cfg_digit;
    logic       opened;
    logic       locked_out;
    logic [1:0] progress;
    logic [1:0] fail_count;

    int checks = 0;
    int failures = 0;

    // Reference model: plain counters of remaining open/lockout cycles.
    int m_code [CODE_LEN];
    int m_prog, m_fails, m_open_left, m_lock_left;

    lock_controller #(
        .DIGIT_W(DIGIT_W), .CODE_LEN(CODE_LEN), .MAX_TRIES(MAX_TRIES),
        .LOCKOUT_CYCLES(LOCK_CYC), .OPEN_CYCLES(OPEN_CYC)
    ) dut (
        .clock_i      (clock),
        .reset_ni     (reset_n),
        .value_i      (value),
        .new_i        (new_s),
        .cfg_we_i     (cfg_we),
        .cfg_idx_i    (cfg_idx),
        .cfg_digit_i  (cfg_digit),
        .opened_o     (opened),
        .locked_out_o (locked_out),
        .progress_o   (progress),
        .fail_count_o (fail_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        if (!reset_n) begin
            for (int i = 0; i < CODE_LEN; i++) m_code[i] = i + 1;
            m_prog = 0; m_fails = 0; m_open_left = 0; m_lock_left = 0;
        end else if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fails = 0;
        end else if (m_open_left > 0) begin
            m_open_left = new_s ? 0 : m_open_left - 1;
        end else if (new_s) begin
            if (int'(value) == m_code[m_prog]) begin
                m_prog++;
                if (m_prog == CODE_LEN) begin
                    m_prog = 0; m_fails = 0; m_open_left = OPEN_CYC;
                end
            end else begin
                m_prog = 0;
                m_fails++;
                if (m_fails == MAX_TRIES) m_lock_left = LOCK_CYC;
            end
        end else if (cfg_we && m_prog == 0 && int'(cfg_idx) < CODE_LEN) begin
            m_code[cfg_idx] = int'(cfg_digit);
        end
    endtask

    // One clock: model follows the edge, outputs are compared 1 time unit later,
    // and control returns at the falling edge where the next inputs are driven.
    task automatic cyc();
        @(posedge clock);
        model_step();
        #1;
        check("opened", int'(opened), (m_open_left > 0) ? 1 : 0);
        check("locked_out", int'(locked_out), (m_lock_left > 0) ? 1 : 0);
        check("progress", int'(progress), m_prog);
        check("fail_count", int'(fail_count), m_fails);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic strobe(input int d);
        new_s = 1'b1; value = 4'(d);
        cyc();
        new_s = 1'b0;
        cyc();
    endtask

    task automatic cfg_write(input int idx, input int d);
        cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_digit = 4'(d);
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; value = '0; new_s = 1'b0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_digit = '0;
        for (int i = 0; i < CODE_LEN; i++) m_code[i] = 0;
        m_prog = 0; m_fails = 0; m_open_left = 0; m_lock_left = 0;
        @(negedge clock);
        cyc();
        reset_n = 1'b1;
        idle(2);

        // Correct code opens for the full hold time
        strobe(1); strobe(2); strobe(3);
        idle(10);

        // Wrong second digit, then a stray 2,3 fails at position 0
        strobe(1); strobe(5); strobe(2); strobe(3);
        idle(2);

        // Lockout: inputs ignored, then normal operation resumes
        do_reset();
        strobe(9); strobe(9); strobe(9);
        strobe(1); strobe(2); strobe(3);
        cfg_write(0, 4);
        idle(12);
        strobe(1); strobe(2); strobe(3);
        idle(10);

        // Reprogram the code, and a write colliding with a strobe
        cfg_write(0, 7); cfg_write(1, 7); cfg_write(2, 7);
        cfg_write(3, 1);
        strobe(1); strobe(2); strobe(3);
        strobe(7); strobe(7); strobe(7);
        idle(9);
        new_s = 1'b1; value = 4'd0; cfg_we = 1'b1; cfg_idx = 2'd0; cfg_digit = 4'd5;
        cyc();
        new_s = 1'b0; cfg_we = 1'b0;
        strobe(7); strobe(7); strobe(7);
        idle(9);

        // Early relock on the third open cycle
        do_reset();
        strobe(1); strobe(2);
        new_s = 1'b1; value = 4'd3;
        cyc();
        new_s = 1'b0;
        idle(2);
        new_s = 1'b1; value = 4'd3;
        cyc();
        new_s = 1'b0;
        idle(2);
        strobe(1); strobe(2); strobe(3);
        idle(9);

        // Reset mid-entry and mid-lockout
        strobe(1); strobe(2);
        do_reset();
        strobe(9); strobe(9); strobe(9);
        idle(5);
        do_reset();
        strobe(1); strobe(2); strobe(3);
        idle(9);

        // Randomized traffic biased towards the current code
        for (int n = 0; n < 4000; n++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            new_s = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) != 0)
                value = 4'(m_code[$urandom_range(0, CODE_LEN - 1)]);
            else
                value = 4'($urandom_range(0, 15));
            cfg_we = ($urandom_range(0, 9) == 0);
            cfg_idx = 2'($urandom_range(0, 3));
            cfg_digit = 4'($urandom_range(0, 15));
            cyc();
        end
        reset_n = 1'b1; new_s = 1'b0; cfg_we = 1'b0;
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
